// File: rtl/keypad_scan_ctrl.sv
// ---------------------------------------------------------------------------
// keypad_scan_ctrl
//
// Scan controller for a 4x4 active-low matrix keypad. A free-running divider
// produces a one-cycle scan tick. On each tick the controller samples the
// synchronized rows for the column it is driving. Presses and releases are
// debounced over DEBOUNCE_TICKS consecutive tick samples. Each accepted press
// is offered downstream as a raw {row, col} index over a valid/ready handshake.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active low
//   row_in     keypad rows, active low, asynchronous to clk
//   col_out    keypad columns, active low, exactly one bit low
//   key_code   raw key index {row[1:0], col[1:0]}
//   key_valid  key_code holds a key that has not been accepted yet
//   key_ready  consumer accepts key_code when key_valid && key_ready
//   key_held   a debounced key is currently pressed
//   overrun    a new key was dropped because the previous one was pending
// ---------------------------------------------------------------------------
module keypad_scan_ctrl #(
    parameter int CLK_HZ         = 27000000,
    parameter int SCAN_HZ        = 1000,
    parameter int DEBOUNCE_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overrun
);

    localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW       = $clog2(DEBOUNCE_TICKS + 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_REPORT,
        ST_HOLD
    } state_e;

    state_e         state_q, state_d;
    logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
    logic [3:0]     row_meta_q, row_s_q;
    logic [1:0]     col_idx_q, col_idx_d;
    logic [1:0]     r_q, r_d;
    logic [1:0]     c_q, c_d;
    logic [DW-1:0]  deb_cnt_q, deb_cnt_d;
    logic [3:0]     key_code_q, key_code_d;
    logic           key_valid_q, key_valid_d;
    logic           key_held_q, key_held_d;
    logic           overrun_q, overrun_d;

    logic           tick;
    logic           rows_idle;
    logic [1:0]     low_row;
    logic [DW-1:0]  deb_inc;
    logic           deb_done;

    // ------------------------------------------------------------------
    // Tick generator: free-runs regardless of FSM state.
    // ------------------------------------------------------------------
    assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

    // ------------------------------------------------------------------
    // Row decode helpers, all on the synchronized rows.
    // ------------------------------------------------------------------
    assign rows_idle = &row_s_q;

    // When several rows are low on the driven column, the lowest row wins.
    always_comb begin
        if (!row_s_q[0])      low_row = 2'd0;
        else if (!row_s_q[1]) low_row = 2'd1;
        else if (!row_s_q[2]) low_row = 2'd2;
        else                  low_row = 2'd3;
    end

    assign deb_inc  = deb_cnt_q + DW'(1);
    assign deb_done = (deb_inc == DW'(DEBOUNCE_TICKS));

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        r_d         = r_q;
        c_d         = c_q;
        deb_cnt_d   = deb_cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        key_held_d  = key_held_q;
        overrun_d   = overrun_q;

        // Consumer handshake; the REPORT load below overrides this when
        // both happen in the same cycle.
        if (key_valid_q && key_ready) begin
            key_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end

        unique case (state_q)
            ST_SCAN: begin
                if (tick) begin
                    if (rows_idle) begin
                        col_idx_d = col_idx_q + 2'd1;
                    end else begin
                        // This sample counts as the first stable one, so
                        // the counter starts at 1 and the column is held.
                        r_d       = low_row;
                        c_d       = col_idx_q;
                        deb_cnt_d = DW'(1);
                        state_d   = (DEBOUNCE_TICKS == 1) ? ST_REPORT : ST_DEBOUNCE;
                    end
                end
            end

            ST_DEBOUNCE: begin
                if (tick) begin
                    if (!row_s_q[r_q]) begin
                        deb_cnt_d = deb_inc;
                        if (deb_done) state_d = ST_REPORT;
                    end else begin
                        // Bounce: drop the candidate and move on.
                        deb_cnt_d = '0;
                        col_idx_d = col_idx_q + 2'd1;
                        state_d   = ST_SCAN;
                    end
                end
            end

            ST_REPORT: begin
                deb_cnt_d  = '0;
                key_held_d = 1'b1;
                state_d    = ST_HOLD;
                if (!key_valid_q || key_ready) begin
                    key_code_d  = {r_q, c_q};
                    key_valid_d = 1'b1;
                    overrun_d   = overrun_q;
                end else begin
                    // Pending key is kept intact; the new one is lost.
                    overrun_d = 1'b1;
                end
            end

            ST_HOLD: begin
                // Release needs consecutive all-high ticks; any low row
                // (the held key or another key) restarts the count.
                if (tick) begin
                    if (rows_idle) begin
                        deb_cnt_d = deb_inc;
                        if (deb_done) begin
                            deb_cnt_d  = '0;
                            key_held_d = 1'b0;
                            col_idx_d  = col_idx_q + 2'd1;
                            state_d    = ST_SCAN;
                        end
                    end else begin
                        deb_cnt_d = '0;
                    end
                end
            end

            default: state_d = ST_SCAN;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_SCAN;
            tick_cnt_q  <= '0;
            row_meta_q  <= 4'b1111;
            row_s_q     <= 4'b1111;
            col_idx_q   <= 2'd0;
            r_q         <= 2'd0;
            c_q         <= 2'd0;
            deb_cnt_q   <= '0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            row_meta_q  <= row_in;
            row_s_q     <= row_meta_q;
            col_idx_q   <= col_idx_d;
            r_q         <= r_d;
            c_q         <= c_d;
            deb_cnt_q   <= deb_cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            overrun_q   <= overrun_d;
        end
    end

    // Column drive decodes straight from the register, so reset reaches
    // the pins without waiting for a clock.
    assign col_out   = ~(4'b0001 << col_idx_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
module tb_keypad_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       key_held;
    logic       overrun;

    // keys[r][c] = 1 means the switch at row r, column c is closed.
    logic [3:0] keys [4];

    int checks   = 0;
    int failures = 0;
    int valid_samples = 0;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(
        .CLK_HZ(4000),
        .SCAN_HZ(1000),
        .DEBOUNCE_TICKS(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .row_in(row_in),
        .col_out(col_out),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key_held(key_held),
        .overrun(overrun)
    );

    // Passive keypad: a row is pulled low when a closed key on it sits on
    // the column currently driven low.
    for (genvar r = 0; r < 4; r++) begin : g_pad
        assign row_in[r] = ~|(keys[r] & ~col_out);
    end

    // Counts cycles with key_valid high (value seen just before each edge).
    always @(posedge clk) if (key_valid) valid_samples <= valid_samples + 1;

    typedef struct {
        int         cyc;
        logic [3:0] col;
        logic [2:0] flags;   // {key_valid, key_held, overrun}
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic probe(input int sel);
        case (sel)
            0:       return key_valid;
            1:       return !key_held;
            2:       return overrun;
            3:       return col_out == 4'b1110;
            default: return 1'b0;
        endcase
    endfunction

    // Step negedges until the probed condition holds or the bound expires.
    task automatic wait_until(input string name, input int sel, input int bound, output int cyc);
        cyc = 0;
        while (!probe(sel) && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
        check(name, probe(sel), 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int cyc;
        int v0;

        tbl[0] = '{1, 4'b1110, 3'b000};
        tbl[1] = '{2, 4'b1110, 3'b000};
        tbl[2] = '{1, 4'b1101, 3'b000};
        tbl[3] = '{3, 4'b1101, 3'b000};
        tbl[4] = '{1, 4'b1011, 3'b000};
        tbl[5] = '{4, 4'b0111, 3'b000};
        tbl[6] = '{4, 4'b1110, 3'b000};

        for (int r = 0; r < 4; r++) keys[r] = 4'b0000;
        key_ready = 1'b1;
        rst = 1'b0;
        step(2);

        check("rst_col",   col_out,   4'b1110);
        check("rst_code",  key_code,  4'h0);
        check("rst_valid", key_valid, 1'b0);
        check("rst_held",  key_held,  1'b0);
        check("rst_ovr",   overrun,   1'b0);

        // 1. Idle scan, one column per 4 clocks.
        rst = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].cyc);
            check($sformatf("idle_col[%0d]", i), col_out, tbl[i].col);
            check($sformatf("idle_flags[%0d]", i), {key_valid, key_held, overrun}, tbl[i].flags);
        end

        // 2. Clean press of row 2 / col 1; column 0 is driven at this point.
        v0 = valid_samples;
        keys[2][1] = 1'b1;
        wait_until("t2_valid", 0, 60, cyc);
        check("t2_latency", cyc, 17);
        check("t2_code", key_code, 4'h9);
        check("t2_held", key_held, 1'b1);
        step(1);
        check("t2_valid_pulse", key_valid, 1'b0);
        step(60);
        check("t2_held_long", key_held, 1'b1);
        check("t2_col_kept", col_out, 4'b1101);
        keys[2][1] = 1'b0;
        wait_until("t2_release", 1, 40, cyc);
        check("t2_resume_col2", col_out, 4'b1011);
        check("t2_one_report", valid_samples - v0, 1);

        // 3. Bounce: key seen on two ticks only.
        wait_until("t3_col0", 3, 40, cyc);
        v0 = valid_samples;
        keys[0][0] = 1'b1;
        step(8);
        check("t3_col_held", col_out, 4'b1110);
        keys[0][0] = 1'b0;
        step(4);
        check("t3_col_next", col_out, 4'b1101);
        check("t3_held", key_held, 1'b0);
        step(2);
        check("t3_no_report", valid_samples - v0, 0);

        // 4. Backpressure and overrun.
        key_ready = 1'b0;
        keys[0][0] = 1'b1;
        wait_until("t4_valid", 0, 100, cyc);
        check("t4_code0", key_code, 4'h0);
        keys[0][0] = 1'b0;
        wait_until("t4_rel0", 1, 100, cyc);
        keys[3][3] = 1'b1;
        wait_until("t4_overrun", 2, 200, cyc);
        check("t4_code_kept", key_code, 4'h0);
        check("t4_valid_kept", key_valid, 1'b1);
        key_ready = 1'b1;
        step(1);
        key_ready = 1'b0;
        check("t4_valid_clr", key_valid, 1'b0);
        check("t4_ovr_clr", overrun, 1'b0);
        keys[3][3] = 1'b0;
        wait_until("t4_rel3", 1, 100, cyc);
        key_ready = 1'b1;

        // 5. Rows 1 and 3 on column 2: lowest row wins.
        keys[1][2] = 1'b1;
        keys[3][2] = 1'b1;
        wait_until("t5_valid", 0, 100, cyc);
        check("t5_code", key_code, 4'h6);
        step(1);
        check("t5_valid_pulse", key_valid, 1'b0);
        keys[1][2] = 1'b0;
        keys[3][2] = 1'b0;
        wait_until("t5_release", 1, 100, cyc);

        // 6. Asynchronous reset while debouncing a key on column 1.
        wait_until("t6_col0", 3, 40, cyc);
        keys[0][1] = 1'b1;
        step(10);
        check("t6_pre_col", col_out, 4'b1101);
        #2 rst = 1'b0;
        #1;
        check("t6_async_col",   col_out,   4'b1110);
        check("t6_async_code",  key_code,  4'h0);
        check("t6_async_valid", key_valid, 1'b0);
        check("t6_async_held",  key_held,  1'b0);
        check("t6_async_ovr",   overrun,   1'b0);
        keys[0][1] = 1'b0;
        step(2);
        rst = 1'b1;
        v0 = valid_samples;
        check("t6_restart_col0", col_out, 4'b1110);
        step(4);
        check("t6_restart_col1", col_out, 4'b1101);
        step(16);
        check("t6_no_stale", valid_samples - v0, 0);
        check("t6_held", key_held, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Scan controller for the 4x4 matrix keypad. It generates its own scan-rate tick enable from the 27 MHz system clock; no derived clock is used. It drives one active-low column at a time and samples the synchronized rows on each tick. Each key press and release is debounced, and the raw key index is delivered downstream over a valid/ready handshake.

Parameters:
CLK_HZ, 27000000, system clock frequency in Hz
SCAN_HZ, 1000, scan tick rate in Hz; TICK_DIV = CLK_HZ/SCAN_HZ, must be >= 2
DEBOUNCE_TICKS, 8, consecutive stable tick samples required for both press and release; must be >= 1

Ports:
clk  input  1  system clock, 27 MHz
rst  input  1  asynchronous, active-low reset
row_in  input  4  keypad rows; active-low, pulled up, asynchronous to clk
col_out  output  4  keypad columns; active-low, exactly one bit low at all times
key_code  output  4  raw key index {row[1:0], col[1:0]}
key_valid  output  1  key_code holds an unaccepted key
key_ready  input  1  consumer accepts key_code when key_valid && key_ready
key_held  output  1  a debounced key is currently pressed
overrun  output  1  a new key was dropped because the previous key was not yet accepted

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low on rst. Every register takes its reset value immediately on rst=0, with no clock edge required.
- Reset values:
  - col_out=4'b1110; col_idx=0.
  - key_code=0, key_valid=0, key_held=0, overrun=0.
  - Tick counter=0; debounce counter=0.
  - Row synchronizer=4'b1111.
  - State=SCAN.
- row_in passes through a 2-flop synchronizer before use. All decisions use the synchronized value (row_s).
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick is a one-cycle pulse in the cycle where the counter == TICK_DIV-1.
  - The counter free-runs in every state.
- col_out = ~(4'b0001 << col_idx). col_idx only changes on a tick in SCAN, or on the transition out of DEBOUNCE or HOLD back to SCAN.
- SCAN:
  - On tick, if row_s == 4'b1111: col_idx <= col_idx+1, wrapping 3 to 0.
  - On tick, if any row_s bit is 0: latch r = lowest-index low row and c = col_idx. Set deb_cnt=1 and go to DEBOUNCE, keeping the column driven.
  - If DEBOUNCE_TICKS == 1, go directly to REPORT instead.
- DEBOUNCE:
  - On tick, if row_s[r] == 0: deb_cnt++. When deb_cnt reaches DEBOUNCE_TICKS, go to REPORT.
  - On tick, if row_s[r] == 1: go to SCAN and advance col_idx. No report is made.
- REPORT (exactly one cycle), then go to HOLD with deb_cnt=0:
  - If key_valid=0, or key_valid=1 with key_ready=1 in this cycle: key_code <= {r,c}, key_valid <= 1.
  - Otherwise (key_valid=1, key_ready=0): key_code and key_valid are unchanged, and overrun <= 1.
- HOLD:
  - key_held=1. The column stays driven.
  - On tick, if row_s == 4'b1111: deb_cnt++. Otherwise deb_cnt <= 0.
  - When deb_cnt reaches DEBOUNCE_TICKS: key_held <= 0, then go to SCAN and advance col_idx.
  - Another key pressed while in HOLD is ignored. It is not queued.
- Handshake:
  - In any cycle with key_valid && key_ready, outside the REPORT load case: key_valid <= 0 and overrun <= 0 on the next edge.
  - key_code stays stable while key_valid=1.
  - If the handshake and a REPORT load happen in the same cycle: the new code loads, key_valid stays 1, and overrun is not set.
- Latency, press to key_valid: 2 sync cycles, plus wait for the next tick, plus (DEBOUNCE_TICKS-1) ticks, plus 1 cycle (REPORT).
- key_held is 1 only in HOLD, and rises together with the REPORT-to-HOLD transition.

Test Plan:
All scenarios use CLK_HZ=4000, SCAN_HZ=1000 (TICK_DIV=4) and DEBOUNCE_TICKS=3.
1. Idle scan: after reset release, row_in=4'hF -> col_out cycles 1110, 1101, 1011, 0111, 1110, changing every 4 clocks; key_valid, key_held and overrun stay 0.
2. Clean press: hold row_in=4'b1011 (row 2) only while col 1 is driven, for 20 ticks, with key_ready=1 -> one-cycle key_valid with key_code=4'h9. key_held=1 until 3 high ticks after release. Scan then resumes at col 2.
3. Bounce: row 0 low on col 0 for 2 ticks, then high -> no key_valid and key_held stays 0. Scan continues with col_out=1101.
4. Backpressure: key_ready=0. Press and release (row0,col0), then press (row3,col3) -> key_code stays 4'h0 and overrun=1. Then pulse key_ready=1 for one cycle -> key_valid=0 and overrun=0 on the next cycle.
5. Multi-row: rows 1 and 3 low while col 2 is driven -> key_code=4'h6.
6. Reset mid-DEBOUNCE: drive rst=0 between clock edges -> col_out=1110 and all outputs zero immediately. After rst=1, scanning restarts at col 0 and no stale key is reported.
